// File: rtl/iq_mixer_dump.sv
// Quadrature mixer with optional integrate-and-dump. Stage 1 registers the
// full-precision products; stage 2 accumulates, rounds, shifts and saturates per channel.

module iq_mixer_dump_chan #(
  parameter int P_W   = 16,
  parameter int ACC_W = 28,
  parameter int SHIFT = 0,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    first,
  input  logic                    last,
  input  logic signed [P_W-1:0]   prod,
  output logic signed [OUT_W-1:0] res,
  output logic                    clip
);
  localparam logic signed [ACC_W:0] AMAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] AMIN = {2'b11, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W:0] OMAX = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] OMIN = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [ACC_W:0]        RND  = ({{ACC_W{1'b0}}, 1'b1} << SHIFT) >> 1;

  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic                    acc_ovf, ovf_nxt, out_clip;
  logic signed [ACC_W:0]   base, prod_x, sum, rnd, shf;
  logic signed [OUT_W-1:0] res_nxt;

  always_comb begin
    base     = first ? '0 : {acc[ACC_W-1], acc};
    prod_x   = {{(ACC_W+1-P_W){prod[P_W-1]}}, prod};
    sum      = base + prod_x;
    ovf_nxt  = first ? 1'b0 : acc_ovf;
    acc_nxt  = sum[ACC_W-1:0];
    if (sum > AMAX) begin
      acc_nxt = AMAX[ACC_W-1:0];
      ovf_nxt = 1'b1;
    end else if (sum < AMIN) begin
      acc_nxt = AMIN[ACC_W-1:0];
      ovf_nxt = 1'b1;
    end
    // headroom bit keeps the rounding add from wrapping
    rnd      = {acc_nxt[ACC_W-1], acc_nxt} + RND;
    shf      = rnd >>> SHIFT;
    out_clip = 1'b0;
    res_nxt  = shf[OUT_W-1:0];
    if (shf > OMAX) begin
      res_nxt  = OMAX[OUT_W-1:0];
      out_clip = 1'b1;
    end else if (shf < OMIN) begin
      res_nxt  = OMIN[OUT_W-1:0];
      out_clip = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
      res     <= '0;
      clip    <= 1'b0;
    end else if (en) begin
      if (last) begin
        res     <= res_nxt;
        clip    <= ovf_nxt | out_clip;
        acc     <= '0;
        acc_ovf <= 1'b0;
      end else begin
        acc     <= acc_nxt;
        acc_ovf <= ovf_nxt;
      end
    end
  end
endmodule

module iq_mixer_dump #(
  parameter int DATA_W = 8,
  parameter int NCO_W  = 8,
  parameter int ACC_W  = 28,
  parameter int SHIFT  = 0,
  parameter int OUT_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] adc_data,
  input  logic signed [NCO_W-1:0]  nco_sin,
  input  logic signed [NCO_W-1:0]  nco_cos,
  input  logic                     sym_sync,
  input  logic                     mode,
  input  logic [CNT_W-1:0]         dump_len,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  I_out,
  output logic signed [OUT_W-1:0]  Q_out,
  output logic                     sat_flag
);
  localparam int P_W    = DATA_W + NCO_W;
  localparam int NUM_CH = 2;
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic                          win_open, mode_l;
  logic [CNT_W-1:0]              cnt, len_l;
  logic                          start, eff_mode, last;
  logic [CNT_W-1:0]              eff_len, idx;
  logic [2:1]                    vld_pipe;
  logic                          s1_first, s1_last;
  logic [NUM_CH-1:0][NCO_W-1:0]  nco;
  logic [NUM_CH-1:0][P_W-1:0]    prod;
  logic [NUM_CH-1:0][OUT_W-1:0]  res;
  logic [NUM_CH-1:0]             clip;

  // ch0 = I (cos), ch1 = Q (sin)
  assign nco = {nco_sin, nco_cos};

  // window bookkeeping is resolved at acceptance so stage 2 only sees first/last
  always_comb begin
    start    = sym_sync | ~win_open;
    eff_mode = start ? mode : mode_l;
    eff_len  = start ? ((dump_len == '0) ? ONE : dump_len) : len_l;
    idx      = start ? '0 : cnt;
    last     = ~eff_mode | (idx == eff_len - ONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      win_open <= 1'b0;
      mode_l   <= 1'b0;
      cnt      <= '0;
      len_l    <= '0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      prod     <= '0;
    end else begin
      vld_pipe[1] <= in_valid;
      vld_pipe[2] <= vld_pipe[1] & s1_last;
      if (in_valid) begin
        win_open <= ~last;
        mode_l   <= eff_mode;
        len_l    <= eff_len;
        cnt      <= idx + ONE;
        s1_first <= start;
        s1_last  <= last;
        for (int ch = 0; ch < NUM_CH; ch++)
          prod[ch] <= P_W'($signed(adc_data)) * P_W'($signed(nco[ch]));
      end
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    iq_mixer_dump_chan #(
      .P_W(P_W), .ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .en   (vld_pipe[1]),
      .first(s1_first),
      .last (s1_last),
      .prod (prod[ch]),
      .res  (res[ch]),
      .clip (clip[ch])
    );
  end

  assign out_valid = vld_pipe[2];
  assign I_out     = res[0];
  assign Q_out     = res[1];
  assign sat_flag  = |clip;
endmodule

// File: tb/tb_iq_mixer_dump.sv
// Three mixer configurations (SHIFT=0, SHIFT=2, narrow ACC/OUT) driven in parallel
// and checked every cycle against a window-level arithmetic model.

module tb_iq_mixer_dump;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, in_valid, sym_sync, mode;
  logic signed [7:0] adc_data, nco_sin, nco_cos;
  logic [15:0]       dump_len;

  logic               ov0, ov1, ov2, sf0, sf1, sf2;
  logic signed [15:0] i0, q0, i1, q1;
  logic signed [11:0] i2, q2;

  iq_mixer_dump #(.SHIFT(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .adc_data(adc_data), .nco_sin(nco_sin),
    .nco_cos(nco_cos), .sym_sync(sym_sync), .mode(mode), .dump_len(dump_len),
    .out_valid(ov0), .I_out(i0), .Q_out(q0), .sat_flag(sf0));
  iq_mixer_dump #(.SHIFT(2)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .adc_data(adc_data), .nco_sin(nco_sin),
    .nco_cos(nco_cos), .sym_sync(sym_sync), .mode(mode), .dump_len(dump_len),
    .out_valid(ov1), .I_out(i1), .Q_out(q1), .sat_flag(sf1));
  iq_mixer_dump #(.ACC_W(16), .SHIFT(1), .OUT_W(12)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .adc_data(adc_data), .nco_sin(nco_sin),
    .nco_cos(nco_cos), .sym_sync(sym_sync), .mode(mode), .dump_len(dump_len),
    .out_valid(ov2), .I_out(i2), .Q_out(q2), .sat_flag(sf2));

  localparam int SHF  [3] = '{0, 2, 1};
  localparam int ACCW [3] = '{28, 28, 16};
  localparam int OUTW [3] = '{16, 16, 12};

  typedef struct { int due; longint i; longint q; bit sat; } exp_t;
  exp_t   exp_q [3][$];
  longint hi [3], hq [3];
  bit     hs [3];
  int     pulses [3];
  int     checks = 0, failures = 0, cyc = 0;

  // model window state
  bit     m_open;
  int     m_cnt, m_len;
  bit     m_mode;
  longint macc [3][2];
  bit     movf [3];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  function automatic longint rsat(input int k, input longint v, output bit clipped);
    longint r, omax;
    r = (v + ((64'sd1 <<< SHF[k]) >>> 1)) >>> SHF[k];
    omax = (64'sd1 <<< (OUTW[k] - 1)) - 1;
    clipped = 1'b0;
    if (r > omax) begin r = omax; clipped = 1'b1; end
    else if (r < -omax - 1) begin r = -omax - 1; clipped = 1'b1; end
    return r;
  endfunction

  task automatic model_reset();
    m_open = 1'b0;
    m_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      exp_q[k].delete();
      hi[k] = 0; hq[k] = 0; hs[k] = 1'b0;
    end
  endtask

  task automatic model_accept(input int a, input int s, input int c, input bit sy,
                              input bit md, input int len);
    longint pr [2];
    longint lim, t;
    bit     c0, c1, fin;
    exp_t   e;
    pr[0] = longint'(a * c);
    pr[1] = longint'(a * s);
    if (sy || !m_open) begin
      m_mode = md;
      m_len  = (len == 0) ? 1 : len;
      m_cnt  = 0;
      for (int k = 0; k < 3; k++) begin
        macc[k][0] = 0; macc[k][1] = 0; movf[k] = 1'b0;
      end
    end
    for (int k = 0; k < 3; k++)
      for (int ch = 0; ch < 2; ch++) begin
        lim = 64'sd1 <<< (ACCW[k] - 1);
        t = macc[k][ch] + pr[ch];
        if (t > lim - 1) begin t = lim - 1; movf[k] = 1'b1; end
        else if (t < -lim) begin t = -lim; movf[k] = 1'b1; end
        macc[k][ch] = t;
      end
    fin = (m_mode == 1'b0) || (m_cnt == m_len - 1);
    if (fin) begin
      for (int k = 0; k < 3; k++) begin
        e.due = cyc + 2;
        e.i   = rsat(k, macc[k][0], c0);
        e.q   = rsat(k, macc[k][1], c1);
        e.sat = movf[k] | c0 | c1;
        exp_q[k].push_back(e);
      end
      m_open = 1'b0;
    end else begin
      m_open = 1'b1;
      m_cnt++;
    end
  endtask

  task automatic compare();
    longint ai [3], aq [3];
    bit     av [3], as [3];
    bit     ev;
    exp_t   e;
    av[0] = ov0; av[1] = ov1; av[2] = ov2;
    as[0] = sf0; as[1] = sf1; as[2] = sf2;
    ai[0] = longint'(i0); ai[1] = longint'(i1); ai[2] = longint'(i2);
    aq[0] = longint'(q0); aq[1] = longint'(q1); aq[2] = longint'(q2);
    for (int k = 0; k < 3; k++) begin
      ev = (exp_q[k].size() > 0) && (exp_q[k][0].due == cyc);
      chk($sformatf("valid%0d", k), longint'(av[k]), longint'(ev));
      if (ev) begin
        e = exp_q[k].pop_front();
        hi[k] = e.i; hq[k] = e.q; hs[k] = e.sat;
      end
      if (av[k]) pulses[k]++;
      chk($sformatf("I%0d", k), ai[k], hi[k]);
      chk($sformatf("Q%0d", k), aq[k], hq[k]);
      chk($sformatf("sat%0d", k), longint'(as[k]), longint'(hs[k]));
    end
  endtask

  task automatic step(input bit r, input bit iv, input int a, input int s, input int c,
                      input bit sy, input bit md, input int len);
    @(negedge clk);
    cyc++;
    compare();
    rst = r; in_valid = iv; adc_data = 8'(a); nco_sin = 8'(s); nco_cos = 8'(c);
    sym_sync = sy; mode = md; dump_len = 16'(len);
    if (r) model_reset();
    else if (iv) model_accept(a, s, c, sy, md, len);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1);
  endtask

  task automatic samp(input int a, input int s, input int c, input bit sy, input bit md,
                      input int len);
    step(1'b0, 1'b1, a, s, c, sy, md, len);
  endtask

  task automatic clr_pulses();
    for (int k = 0; k < 3; k++) pulses[k] = 0;
  endtask

  initial begin
    bit cur_md;
    int cur_len;
    rst = 1'b1; in_valid = 1'b0; adc_data = '0; nco_sin = '0; nco_cos = '0;
    sym_sync = 1'b0; mode = 1'b0; dump_len = 16'd1;
    model_reset();
    repeat (2) @(posedge clk);
    step(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1);
    step(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1);
    chk("rst_valid", longint'(ov0), 0);
    chk("rst_I", longint'(i0), 0);
    chk("rst_sat", longint'(sf1), 0);

    // per-sample products
    samp(100, -128, 127, 1'b0, 1'b0, 1);
    idle(2);
    chk("t1_valid", longint'(ov0), 1);
    chk("t1_I", longint'(i0), 12700);
    chk("t1_Q", longint'(q0), -12800);

    // largest product, then rounding with SHIFT=2
    samp(-128, 0, -128, 1'b0, 1'b0, 1);
    samp(3, 0, 1, 1'b0, 1'b0, 1);
    samp(-3, 0, 1, 1'b0, 1'b0, 1);
    chk("t2_I", longint'(i0), 16384);
    chk("t2_sat", longint'(sf0), 0);
    idle(1);
    chk("t2_rnd_pos", longint'(i1), 1);
    idle(1);
    chk("t2_rnd_neg", longint'(i1), -1);
    idle(2);

    // two windows of four with bubbles
    clr_pulses();
    for (int j = 0; j < 12; j++)
      if (j % 3 == 2) idle(1);
      else samp(127, 0, 127, 1'b0, 1'b1, 4);
    idle(3);
    chk("t3_pulses", longint'(pulses[1]), 2);
    chk("t3_I", longint'(i1), 16129);
    chk("t3_Q", longint'(q1), 0);
    chk("t4_I", longint'(i0), 32767);
    chk("t4_sat", longint'(sf0), 1);
    chk("t4_acc_sat", longint'(sf2), 1);

    // sym_sync drops the partial window
    clr_pulses();
    samp(10, 2, 1, 1'b0, 1'b1, 4);
    samp(10, 2, 1, 1'b0, 1'b1, 4);
    samp(1, 2, 1, 1'b1, 1'b1, 4);
    samp(2, 2, 1, 1'b0, 1'b1, 4);
    samp(3, 2, 1, 1'b0, 1'b1, 4);
    samp(4, 2, 1, 1'b0, 1'b1, 4);
    idle(3);
    chk("t5_pulses", longint'(pulses[0]), 1);
    chk("t5_I", longint'(i0), 10);
    chk("t5_Q", longint'(q0), 20);

    // reset mid-window, then dump_len=0 dumps every sample
    clr_pulses();
    samp(5, 5, 5, 1'b0, 1'b1, 4);
    samp(5, 5, 5, 1'b0, 1'b1, 4);
    step(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1, 0);
    for (int j = 0; j < 5; j++) samp(j + 1, 0, 2, 1'b0, 1'b1, 0);
    idle(3);
    chk("t6_pulses", longint'(pulses[0]), 5);
    chk("t6_I", longint'(i0), 10);

    // randomized traffic with mid-window mode/len changes, syncs and resets
    cur_md = 1'b1;
    cur_len = 3;
    for (int j = 0; j < 3000; j++) begin
      if ($urandom_range(0, 49) == 0) cur_md = ~cur_md;
      if ($urandom_range(0, 29) == 0)
        cur_len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 20))
                                              : int'($urandom_range(0, 6));
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
           int'($urandom_range(0, 255)) - 128, ($urandom_range(0, 19) == 0),
           cur_md, cur_len);
    end
    idle(4);
    for (int k = 0; k < 3; k++)
      chk($sformatf("drain%0d", k), longint'(exp_q[k].size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
